hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised load-use hazard controller for the in-order pipeline, replacing the single-cycle EX-only compare. Adds per-register scoreboard countdowns for multi-cycle load latency, source-valid qualification, zero-register exemption, a memory-wait pipeline freeze, branch flush of IF/ID, and stall statistics with a watchdog. Sits between ID and EX. Drives PC write-enable, IF/ID write-enable and flush, and ID/EX bubble insertion.

Parameters:
REG_AW, 3, register-specifier width; NUM_REGS = 2**REG_AW
LOAD_LAT, 0, extra cycles after a load leaves EX before its data is forwardable; 0 gives the classic single bubble
ZERO_REG, 1, 1 = register 0 is hardwired and never causes a hazard
CNT_W, 16, width of the saturating stall-cycle counter
WD_LIMIT, 15, consecutive non-RUN cycles that trip the watchdog

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
id_rs  in  REG_AW  ID source 1
id_rs_used  in  1  ID instruction reads rs
id_rt  in  REG_AW  ID source 2
id_rt_used  in  1  ID instruction reads rt
id_valid  in  1  ID holds a real instruction
ex_valid  in  1  EX holds a real instruction
ex_memread  in  1  EX instruction is a load
ex_rt  in  REG_AW  load destination in EX
mem_ready  in  1  data memory can complete this cycle; 0 freezes the pipe
branch_taken  in  1  EX resolved a taken branch/jump
hazard  out  1  insert bubble into ID/EX
pc_write  out  1  PC write enable
if_id_write  out  1  IF/ID write enable
if_id_flush  out  1  zero IF/ID on next edge
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
stall_count  out  CNT_W  total load-use stall cycles, saturating
wd_error  out  1  sticky watchdog flag

Behaviour:
- Reset (sampled at clk edge): all scoreboard counters 0, FSM = RUN, stall_count 0, wd_error 0, consecutive counter 0. While reset is high, outputs are forced: hazard 0, pc_write 1, if_id_write 1, if_id_flush 0, pipe_freeze 0. Reset mid-stall clears all pending state.
- Source match: src_hit(r) = used && id_valid && !(ZERO_REG && r==0) && ((ex_valid && ex_memread && ex_rt==r && !(ZERO_REG && ex_rt==0)) || sb[r]!=0).
- load_use = src_hit(id_rs) || src_hit(id_rt).
- Output priority, combinational, same cycle:
  - Freeze when !mem_ready: pipe_freeze 1, pc_write 0, if_id_write 0, hazard 0, if_id_flush 0.
  - Flush when branch_taken: if_id_flush 1, hazard 1 (squash ID), pc_write 1, if_id_write 1. Overrides load_use.
  - Stall when load_use: hazard 1, pc_write 0, if_id_write 0.
  - Otherwise: hazard 0, pc_write 1, if_id_write 1.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1), minimum 1.
  - On a non-frozen edge with ex_valid && ex_memread && !branch_taken, sb[ex_rt] <= LOAD_LAT. This set has priority over the decrement of the same entry.
  - Every other nonzero entry decrements by 1 on each non-frozen edge.
  - All entries hold while frozen.
  - LOAD_LAT=0: scoreboard is always 0, giving exactly one bubble per load-use.
- FSM, for statistics: states RUN, STALL, FREEZE. Next state is FREEZE if !mem_ready, else STALL if load_use && !branch_taken, else RUN.
- stall_count increments on each edge where the stall branch is taken and saturates at all-ones.
- Consecutive counter increments while next state != RUN and clears on RUN. When it reaches WD_LIMIT, wd_error <= 1 and stays set until reset.
- Simultaneous load into EX and match in ID: stall regardless of scoreboard value.

Decomposition:
- Shared package hazard_pkg holds the FSM state enum {RUN, STALL, FREEZE}, REG_AW default, and a function computing the scoreboard counter width.
- One sub-module, sb_entry: a single countdown with set, dec and hold inputs and a busy output, instantiated NUM_REGS times via generate.

Test Plan:
- LOAD_LAT=0: load r3 in EX, ID uses rs=3 -> hazard=1, pc_write=0 for exactly 1 cycle; stall_count=1.
- LOAD_LAT=2: load r5 leaves EX, dependent instruction follows -> 3 total stall cycles, then RUN; stall_count=3.
- ZERO_REG=1: load r0 with ID rs=0 -> hazard=0. Also: id_rt_used=0 with rt match -> no stall.
- mem_ready=0 for 4 cycles during a pending LOAD_LAT=2 entry -> pipe_freeze=1 throughout, sb holds, and the stall resumes with the same remaining count afterwards.
- branch_taken with load_use in the same cycle -> if_id_flush=1, hazard=1, pc_write=1; stall_count unchanged. Reset asserted mid-stall -> next cycle all outputs at RUN values.
- WD_LIMIT=15: mem_ready=0 for 15 cycles -> wd_error rises on the 15th edge and stays 1 after mem_ready returns, until reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam int REG_AW_DEF = 3;

  // A countdown must hold LOAD_LAT; keep at least one bit so LOAD_LAT=0 still elaborates.
  function automatic int sb_width(input int lat);
    return (lat <= 0) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a down-counter loaded when a load leaves EX, busy while nonzero.
module sb_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic         dec,
  input  logic         hold,
  input  logic [W-1:0] set_val,
  output logic         busy
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!hold) begin
      if (set) begin
        cnt_q <= set_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard controller between ID and EX: stall, flush, freeze and stall statistics.
//   state  | meaning
//   RUN    | pipeline advancing normally
//   STALL  | load-use bubble being inserted
//   FREEZE | data memory not ready, whole pipe held
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 0,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              hazard,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_count,
  output logic              wd_error
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int SB_W     = sb_width(LOAD_LAT);
  localparam int WD_W     = $clog2(WD_LIMIT + 1) + 1;
  localparam logic [SB_W-1:0] LAT_V = SB_W'(LOAD_LAT);
  localparam logic [WD_W-1:0] WD_V  = WD_W'(WD_LIMIT);

  logic [NUM_REGS-1:0] busy;
  logic                load_ex, sb_set, rs_hit, rt_hit, load_use, stall_take;
  state_t              state_q, state_nxt;
  logic [WD_W-1:0]     consec_q, consec_nxt;

  assign load_ex = ex_valid && ex_memread;
  assign sb_set  = load_ex && !branch_taken;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
    sb_entry #(.W(SB_W)) u_sb (
      .clk     (clk),
      .reset   (reset),
      .set     (sb_set && (ex_rt == REG_AW'(g))),
      .dec     (1'b1),
      .hold    (!mem_ready),
      .set_val (LAT_V),
      .busy    (busy[g])
    );
  end

  // An EX match with a nonzero source implies a nonzero ex_rt, so one zero test suffices.
  assign rs_hit = id_rs_used && id_valid && !(ZERO_REG && (id_rs == '0)) &&
                  ((load_ex && (ex_rt == id_rs)) || busy[id_rs]);
  assign rt_hit = id_rt_used && id_valid && !(ZERO_REG && (id_rt == '0)) &&
                  ((load_ex && (ex_rt == id_rt)) || busy[id_rt]);
  assign load_use   = rs_hit || rt_hit;
  assign stall_take = mem_ready && !branch_taken && load_use;

  always_comb begin
    hazard      = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!reset) begin
      if (!mem_ready) begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        hazard      = 1'b1;
      end else if (load_use) begin
        hazard      = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
    end
  end

  always_comb begin
    if (!mem_ready)                      state_nxt = FREEZE;
    else if (load_use && !branch_taken)  state_nxt = STALL;
    else                                 state_nxt = RUN;

    if (state_nxt == RUN)        consec_nxt = '0;
    else if (state_q == RUN)     consec_nxt = WD_W'(1);
    else if (consec_q >= WD_V)   consec_nxt = consec_q;
    else                         consec_nxt = consec_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      consec_q    <= '0;
      stall_count <= '0;
      wd_error    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      consec_q <= consec_nxt;
      if (stall_take && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (consec_nxt >= WD_V) begin
        wd_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: two instances (LOAD_LAT 0 and 2) driven in lockstep against a reference model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset, id_rs_used, id_rt_used, id_valid, ex_valid, ex_memread, mem_ready, branch_taken;
  logic [2:0] id_rs, id_rt, ex_rt;
  logic       h0, pw0, iw0, fl0, fz0, wd0;
  logic       h2, pw2, iw2, fl2, fz2, wd2;
  logic [15:0] c0, c2;
  logic [4:0] o0, o2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(3), .LOAD_LAT(0), .ZERO_REG(1'b1), .CNT_W(16), .WD_LIMIT(15)) dut0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .id_valid(id_valid), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .mem_ready(mem_ready), .branch_taken(branch_taken), .hazard(h0),
    .pc_write(pw0), .if_id_write(iw0), .if_id_flush(fl0), .pipe_freeze(fz0),
    .stall_count(c0), .wd_error(wd0));

  hazard_scoreboard #(.REG_AW(3), .LOAD_LAT(2), .ZERO_REG(1'b1), .CNT_W(16), .WD_LIMIT(15)) dut2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .id_valid(id_valid), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .mem_ready(mem_ready), .branch_taken(branch_taken), .hazard(h2),
    .pc_write(pw2), .if_id_write(iw2), .if_id_flush(fl2), .pipe_freeze(fz2),
    .stall_count(c2), .wd_error(wd2));

  assign o0 = {h0, pw0, iw0, fl0, fz0};
  assign o2 = {h2, pw2, iw2, fl2, fz2};

  typedef struct packed {
    logic       rst;
    logic [2:0] rs;
    logic       rs_u;
    logic [2:0] rt;
    logic       rt_u;
    logic       idv;
    logic       exv;
    logic       exm;
    logic [2:0] exrt;
    logic       mr;
    logic       br;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  // Output word order {hazard, pc_write, if_id_write, if_id_flush, pipe_freeze}
  localparam logic [4:0] O_RUN   = 5'b01100;
  localparam logic [4:0] O_STALL = 5'b10000;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_FRZ   = 5'b00001;

  // Reference model: remaining not-ready cycles per register, per instance
  int lat[2] = '{0, 2};
  int rem[2][8];
  int m_cnt[2];
  int m_consec[2];
  bit m_wd[2];

  function automatic stim_t mk(bit rst, int rs, bit rsu, int rt, bit rtu, bit idv,
                               bit exv, bit exm, int exrt, bit mr, bit br);
    stim_t s;
    s.rst = rst; s.rs = 3'(rs); s.rs_u = rsu; s.rt = 3'(rt); s.rt_u = rtu;
    s.idv = idv; s.exv = exv; s.exm = exm; s.exrt = 3'(exrt); s.mr = mr; s.br = br;
    return s;
  endfunction

  function automatic bit m_hit(int k, bit used, logic [2:0] r, stim_t s);
    if (!used || !s.idv || r == 3'd0) return 1'b0;
    return (s.exv && s.exm && s.exrt == r) || (rem[k][r] > 0);
  endfunction

  function automatic bit m_lu(int k, stim_t s);
    return m_hit(k, s.rs_u, s.rs, s) || m_hit(k, s.rt_u, s.rt, s);
  endfunction

  function automatic logic [4:0] m_out(int k, stim_t s);
    if (s.rst) return O_RUN;
    if (!s.mr) return O_FRZ;
    if (s.br) return O_FLUSH;
    if (m_lu(k, s)) return O_STALL;
    return O_RUN;
  endfunction

  task automatic m_edge(int k, stim_t s);
    bit lu;
    bit stall_st;
    if (s.rst) begin
      for (int r = 0; r < 8; r++) rem[k][r] = 0;
      m_cnt[k] = 0; m_consec[k] = 0; m_wd[k] = 1'b0;
    end else begin
      lu = m_lu(k, s);
      stall_st = lu && !s.br;
      if (s.mr) begin
        if (stall_st && m_cnt[k] < 65535) m_cnt[k]++;
        for (int r = 0; r < 8; r++) begin
          if (s.exv && s.exm && !s.br && s.exrt == 3'(r)) rem[k][r] = lat[k];
          else if (rem[k][r] > 0) rem[k][r]--;
        end
      end
      if (!s.mr || stall_st) m_consec[k]++;
      else m_consec[k] = 0;
      if (m_consec[k] >= 15) m_wd[k] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with pre-edge outputs sampled.
  task automatic step(input stim_t s, input string tag, output logic [4:0] s0, output logic [4:0] s2);
    reset = s.rst; id_rs = s.rs; id_rs_used = s.rs_u; id_rt = s.rt; id_rt_used = s.rt_u;
    id_valid = s.idv; ex_valid = s.exv; ex_memread = s.exm; ex_rt = s.exrt;
    mem_ready = s.mr; branch_taken = s.br;
    #1;
    s0 = o0; s2 = o2;
    chk({tag, "/out_lat0"}, 32'(o0), 32'(m_out(0, s)));
    chk({tag, "/out_lat2"}, 32'(o2), 32'(m_out(1, s)));
    m_edge(0, s);
    m_edge(1, s);
    @(posedge clk);
    #1;
    chk({tag, "/cnt_lat0"}, 32'(c0), 32'(m_cnt[0]));
    chk({tag, "/cnt_lat2"}, 32'(c2), 32'(m_cnt[1]));
    chk({tag, "/wd_lat0"}, 32'(wd0), 32'(m_wd[0]));
    chk({tag, "/wd_lat2"}, 32'(wd2), 32'(m_wd[1]));
    @(negedge clk);
  endtask

  task automatic addv(input stim_t s, input logic [4:0] e, input string n);
    vec_t v;
    v.s = s; v.exp = e; v.name = n;
    vq.push_back(v);
  endtask

  initial begin
    logic [4:0] a0, a2;
    stim_t rst_s, idle, s;
    int cnt_before;

    rst_s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    addv(idle,                                   O_RUN,   "idle");
    addv(mk(0, 3, 1, 0, 0, 1, 1, 1, 3, 1, 0),    O_STALL, "lu_rs");
    addv(mk(0, 0, 0, 3, 1, 1, 1, 1, 3, 1, 0),    O_STALL, "lu_rt");
    addv(mk(0, 0, 0, 3, 0, 1, 1, 1, 3, 1, 0),    O_RUN,   "rt_unused");
    addv(mk(0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0),    O_RUN,   "zero_reg");
    addv(mk(0, 3, 1, 0, 0, 0, 1, 1, 3, 1, 0),    O_RUN,   "id_invalid");
    addv(mk(0, 3, 1, 0, 0, 1, 0, 1, 3, 1, 0),    O_RUN,   "ex_invalid");
    addv(mk(0, 3, 1, 0, 0, 1, 1, 0, 3, 1, 0),    O_RUN,   "not_load");
    addv(mk(0, 4, 1, 5, 1, 1, 1, 1, 6, 1, 0),    O_RUN,   "no_match");
    addv(mk(0, 3, 1, 0, 0, 1, 1, 1, 3, 1, 1),    O_FLUSH, "branch_lu");
    addv(mk(0, 3, 1, 0, 0, 1, 1, 1, 3, 0, 0),    O_FRZ,   "freeze_lu");
    addv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),    O_FRZ,   "freeze_branch");
    addv(mk(1, 3, 1, 0, 0, 1, 1, 1, 3, 0, 1),    O_RUN,   "reset_forced");

    reset = 1'b1; id_rs = '0; id_rs_used = 0; id_rt = '0; id_rt_used = 0; id_valid = 0;
    ex_valid = 0; ex_memread = 0; ex_rt = '0; mem_ready = 1; branch_taken = 0;
    @(negedge clk);

    step(rst_s, "reset", a0, a2);
    chk("reset/cnt", 32'(c0), 0);
    chk("reset/wd", 32'(wd2), 0);

    foreach (vq[i]) begin
      step(vq[i].s, vq[i].name, a0, a2);
      chk({"vec/", vq[i].name}, 32'(a0), 32'(vq[i].exp));
    end

    // Single bubble with LOAD_LAT=0
    step(rst_s, "lat0_rst", a0, a2);
    step(mk(0, 3, 1, 0, 0, 1, 1, 1, 3, 1, 0), "lat0_a", a0, a2);
    chk("lat0_stall", 32'(a0), 32'(O_STALL));
    step(mk(0, 3, 1, 0, 0, 1, 0, 0, 0, 1, 0), "lat0_b", a0, a2);
    chk("lat0_release", 32'(a0), 32'(O_RUN));
    chk("lat0_count", 32'(c0), 1);

    // Three stall cycles with LOAD_LAT=2
    step(rst_s, "lat2_rst", a0, a2);
    step(mk(0, 5, 1, 0, 0, 1, 1, 1, 5, 1, 0), "lat2_a", a0, a2);
    chk("lat2_first", 32'(a2[4]), 1);
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0), "lat2_b", a0, a2);
      chk($sformatf("lat2_hz%0d", i), 32'(a2[4]), (i < 2) ? 1 : 0);
    end
    chk("lat2_count", 32'(c2), 3);

    // Freeze holds a pending scoreboard entry
    step(rst_s, "frz_rst", a0, a2);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0), "frz_load", a0, a2);
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0), "frz_hold", a0, a2);
      chk($sformatf("frz_out%0d", i), 32'(a2), 32'(O_FRZ));
    end
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0), "frz_resume", a0, a2);
      chk($sformatf("frz_hz%0d", i), 32'(a2[4]), (i < 2) ? 1 : 0);
    end
    chk("frz_count", 32'(c2), 2);

    // Branch overrides load-use and leaves no scoreboard entry
    step(rst_s, "br_rst", a0, a2);
    cnt_before = int'(c0);
    step(mk(0, 3, 1, 0, 0, 1, 1, 1, 3, 1, 1), "br_a", a0, a2);
    chk("br_flush", 32'(a2), 32'(O_FLUSH));
    chk("br_count", 32'(c0), 32'(cnt_before));
    step(mk(0, 3, 1, 0, 0, 1, 0, 0, 0, 1, 0), "br_b", a0, a2);
    chk("br_no_sb", 32'(a2), 32'(O_RUN));

    // Reset mid-stall clears pending entries
    step(rst_s, "rms_rst", a0, a2);
    step(mk(0, 5, 1, 0, 0, 1, 1, 1, 5, 1, 0), "rms_a", a0, a2);
    step(mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0), "rms_b", a0, a2);
    chk("rms_stalling", 32'(a2), 32'(O_STALL));
    step(mk(1, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0), "rms_r", a0, a2);
    chk("rms_forced", 32'(a2), 32'(O_RUN));
    step(mk(0, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0), "rms_c", a0, a2);
    chk("rms_after", 32'(a2), 32'(O_RUN));
    chk("rms_count", 32'(c2), 0);

    // Watchdog trips on the 15th consecutive frozen edge and is sticky
    step(rst_s, "wd_rst", a0, a2);
    for (int i = 0; i < 14; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wd_frz", a0, a2);
    chk("wd_before", 32'(wd0), 0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wd_frz", a0, a2);
    chk("wd_trip", 32'(wd0), 1);
    for (int i = 0; i < 3; i++) step(idle, "wd_run", a0, a2);
    chk("wd_sticky", 32'(wd2), 1);
    step(rst_s, "wd_clr", a0, a2);
    chk("wd_cleared", 32'(wd0), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom % 50) == 0, $urandom % 4, $urandom % 2, $urandom % 4, $urandom % 2,
             ($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 4,
             ($urandom % 8) != 0, ($urandom % 6) == 0);
      step(s, "rand", a0, a2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
